// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads IF/ID.
// Taken branches and local jumps redirect the PC; fetch halts past the end of the program image.
module fetch_unit #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      ROWS     = 15,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_pc2,
  input  logic [5:0]       br_offset,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] ifid_inst,
  output logic [WIDTH-1:0] ifid_pc2,
  output logic             ifid_valid,
  output logic             halt,
  output logic [WIDTH-1:0] fetch_count
);

  typedef enum logic {RUN, HALT} state_e;

  localparam logic [WIDTH-1:0] EVEN_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ifid_inst_q, ifid_inst_d;
  logic [WIDTH-1:0] ifid_pc2_q, ifid_pc2_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [WIDTH-1:0] fetch_count_q, fetch_count_d;

  logic [WIDTH-1:0] pc_plus2;
  logic [WIDTH-1:0] br_sum;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] jmp_target;
  logic             jmp_det;
  logic             end_cond;

  assign pc_plus2   = pc_q + WIDTH'(2);
  assign br_sum     = br_pc2 + {{(WIDTH-7){br_offset[5]}}, br_offset, 1'b0};
  assign br_target  = br_sum & EVEN_MASK;
  assign jmp_det    = ifid_valid_q && (ifid_inst_q[15:12] == 4'b1101);
  assign jmp_target = {ifid_pc2_q[WIDTH-1:13], ifid_inst_q[11:0], 1'b0};
  assign end_cond   = pc_q[WIDTH-1:1] >= (WIDTH-1)'(ROWS);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_inst_d   = ifid_inst_q;
    ifid_pc2_d    = ifid_pc2_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;

    if (br_taken) begin
      pc_d         = br_target;
      ifid_valid_d = 1'b0;
      state_d      = RUN;
    end else if (stall) begin
      // hold everything
    end else if (jmp_det) begin
      // squash the word fetched alongside the jump
      pc_d         = jmp_target;
      ifid_valid_d = 1'b0;
    end else if (state_q == RUN && end_cond) begin
      ifid_valid_d = 1'b0;
      state_d      = HALT;
    end else if (state_q == HALT) begin
      ifid_valid_d = 1'b0;
    end else begin
      pc_d          = pc_plus2;
      ifid_inst_d   = imem_data;
      ifid_pc2_d    = pc_plus2;
      ifid_valid_d  = 1'b1;
      fetch_count_d = (fetch_count_q == '1) ? fetch_count_q : fetch_count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC & EVEN_MASK;
      ifid_inst_q   <= '0;
      ifid_pc2_q    <= '0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_inst_q   <= ifid_inst_d;
      ifid_pc2_q    <= ifid_pc2_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_inst   = ifid_inst_q;
  assign ifid_pc2    = ifid_pc2_q;
  assign ifid_valid  = ifid_valid_q;
  assign halt        = (state_q == HALT);
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit RISC core. Owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register consumed by decode/control. Resolves unconditional jumps (opcode 1101) locally from the IF/ID register, accepts taken-branch redirects from execute, honours decode stalls, and halts fetch when the PC runs past the end of the program image.

## Interface
- WIDTH, 16, datapath and address width
- ROWS, 15, number of valid instruction words in instruction memory
- RESET_PC, 16'h0000, PC value after reset (bit 0 must be 0)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- stall  in  1  decode hazard stall; hold PC and IF/ID
- br_taken  in  1  execute resolved a BEQ/BNE as taken this cycle
- br_pc2  in  WIDTH  PC+2 of that branch instruction
- br_offset  in  6  signed word offset of that branch
- imem_addr  out  WIDTH  byte address to instruction memory (= PC)
- imem_data  in  WIDTH  instruction word at imem_addr, combinational read
- ifid_inst  out  WIDTH  registered instruction for decode
- ifid_pc2  out  WIDTH  registered PC+2 of ifid_inst
- ifid_valid  out  1  ifid_inst is a real instruction (0 = bubble)
- halt  out  1  fetch stopped past program end
- fetch_count  out  WIDTH  count of instructions loaded valid into IF/ID, saturating

## Operation
- State machine: RUN, HALT. halt = (state == HALT), registered.
- imem_addr = PC; PC bit 0 always 0 (targets have bit 0 forced to 0).
- End condition: PC[15:1] >= ROWS.
- Branch target = br_pc2 + (sign_extend(br_offset) << 1), modulo 2^16.
- Jump detected when ifid_valid and ifid_inst[15:12] == 4'b1101; target = {ifid_pc2[15:13], ifid_inst[11:0], 1'b0}.
- Per-edge priority, first match wins:
  1. br_taken: PC <= branch target; ifid_valid <= 0; state <= RUN. Overrides stall, jump and HALT.
  2. stall: PC, IF/ID, state, fetch_count all hold.
  3. jump detected: PC <= jump target; ifid_valid <= 0 (squash word fetched this cycle).
  4. state RUN and end condition: PC holds; ifid_valid <= 0; state <= HALT.
  5. state HALT: PC holds; ifid_valid <= 0.
  6. otherwise: PC <= PC+2 (wraps 16'hFFFE -> 0); ifid_inst <= imem_data; ifid_pc2 <= PC+2; ifid_valid <= 1; fetch_count <= fetch_count+1, saturating at 16'hFFFF.
- Bubbles leave ifid_inst/ifid_pc2 at their previous value; downstream qualifies with ifid_valid.
- A target at or past ROWS is accepted; HALT is entered on the following edge.

## Timing
- Reset (asynchronous, immediate): PC = RESET_PC, ifid_inst = 0, ifid_pc2 = 0, ifid_valid = 0, state RUN (halt = 0), fetch_count = 0.
- First edge after rst falls: IF/ID holds word at RESET_PC, ifid_valid = 1.
- Fetch latency: 1 cycle from imem_addr to ifid_inst.
- Jump penalty: 1 bubble. Taken-branch penalty: 1 bubble at IF/ID (older stages flushed downstream).
- Stall is level-sensitive; no data lost for any stall length.
- HALT entered 1 edge after PC meets end condition; exited only by br_taken or rst.
- rst asserted mid-operation: all state to reset values at once, regardless of clk.

## Test plan
- Sequential fetch: imem[i] = 16'h2000+i, rst released -> ifid_pc2 2,4,6,... with ifid_inst 2000,2001,2002; fetch_count 1,2,3; ifid_valid = 1 from first edge.
- Stall: stall high 3 cycles while PC = 6 -> imem_addr stays 6, IF/ID and fetch_count unchanged; next edge loads word 3, pc2 = 8.
- Jump: 16'hD005 at address 4 -> after it reaches IF/ID, one bubble (ifid_valid = 0), PC = 16'h000A, then ifid_pc2 = 16'h000C; fetch_count not incremented on bubble.
- Branch beats stall and jump: br_taken = 1, br_pc2 = 16'h0008, br_offset = 6'b111110, stall = 1, jump in IF/ID -> PC = 16'h0004, ifid_valid = 0.
- End of program, ROWS = 15: PC reaches 16'h001E -> next edge halt = 1, ifid_valid = 0, PC held at 16'h001E; br_taken with br_pc2 = 16'h0002, br_offset = 6'b111111 -> halt = 0, PC = 0, fetch resumes.
- Async reset mid-run: rst raised between edges at PC = 16'h000C -> PC, IF/ID, fetch_count, halt go to reset values before next edge; fetch restarts at RESET_PC after release.
